// File: rtl/synth_envelope_ctrl.sv
// synth_envelope_ctrl
// ADSR envelope sequencer for the synth voice VCA. Sits on the CPU memory
// bus, advances one step per audio sample (rising edge of the DAC LR clock)
// and drives a registered 16-bit unsigned level.
// Optional build macro: ENV_EXP_RELEASE_EN -- when defined, DECAY and RELEASE
// use an exponential decrement ((level >> reg[3:0]) + 1) instead of the
// linear rate register value.
module synth_envelope_ctrl #(
   parameter logic [15:0] ATTACK_RST  = 16'h0100,
   parameter logic [15:0] DECAY_RST   = 16'h0040,
   parameter logic [15:0] SUSTAIN_RST = 16'hC000,
   parameter logic [15:0] RELEASE_RST = 16'h0020
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sample_tick_in,
   input  logic [31:0] address_in,
   input  logic        sel_in,
   input  logic        read_in,
   output logic [31:0] read_value_out,
   input  logic [3:0]  write_mask_in,
   input  logic [31:0] write_value_in,
   output logic        ready_out,
   output logic [15:0] level_out,
   output logic [2:0]  state_out
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ATTACK  = 3'd1;
   localparam logic [2:0] ST_DECAY   = 3'd2;
   localparam logic [2:0] ST_SUSTAIN = 3'd3;
   localparam logic [2:0] ST_RELEASE = 3'd4;

   logic        r_tick_q;
   logic        r_gate;
   logic        r_pend_on;
   logic        r_pend_off;
   logic [15:0] r_attack;
   logic [15:0] r_decay;
   logic [15:0] r_sustain;
   logic [15:0] r_release;
   logic [15:0] r_level;
   logic [2:0]  r_state;

   logic        w_tick;
   logic        w_wr_en;
   logic [2:0]  w_reg_sel;
   logic        w_ctrl_wr;
   logic        w_set_on;
   logic        w_set_off;
   logic [16:0] w_att_sum;
   logic [16:0] w_dec_step;
   logic [16:0] w_rel_step;
   logic [17:0] w_dec_floor;
   logic [2:0]  w_eff_state;
   logic        w_clr_on;
   logic        w_clr_off;
   logic [2:0]  w_next_state;
   logic [15:0] w_next_level;
   logic [31:0] w_read_data;
   logic        w_unused;

   // Bus decode, tick edge detect and gate-event capture.
   assign w_tick    = sample_tick_in & ~r_tick_q;
   assign w_wr_en   = sel_in && (write_mask_in[1:0] == 2'b11);
   assign w_reg_sel = address_in[4:2];
   assign w_ctrl_wr = w_wr_en && (w_reg_sel == 3'd0);
   assign w_set_on  = w_ctrl_wr && ((write_value_in[0] && !r_gate) || write_value_in[1]);
   assign w_set_off = w_ctrl_wr && (!write_value_in[0] && r_gate);
   assign ready_out = sel_in;
   assign level_out = r_level;
   assign state_out = r_state;
   assign w_unused  = &{1'b0, address_in[31:5], address_in[1:0],
                        write_mask_in[3:2], write_value_in[31:16]};

   // Step sizes; all sums are kept one or two bits wider so nothing wraps.
   assign w_att_sum = {1'b0, r_level} + {1'b0, r_attack};
`ifdef ENV_EXP_RELEASE_EN
   assign w_dec_step = {1'b0, r_level >> r_decay[3:0]} + 17'd1;
   assign w_rel_step = {1'b0, r_level >> r_release[3:0]} + 17'd1;
`else
   assign w_dec_step = {1'b0, r_decay};
   assign w_rel_step = {1'b0, r_release};
`endif
   assign w_dec_floor = {2'b00, r_sustain} + {1'b0, w_dec_step};

   // Per-tick envelope step: pick the effective state, then apply its rule.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      w_eff_state  = r_state;
      w_clr_on     = 1'b0;
      w_clr_off    = 1'b0;
      if (r_pend_on) begin
         w_eff_state = ST_ATTACK;
         w_clr_on    = 1'b1;
      end else if (r_pend_off || (!r_gate && (r_state inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN}))) begin
         w_eff_state = ST_RELEASE;
         w_clr_off   = 1'b1;
      end

      w_next_state = w_eff_state;
      w_next_level = r_level;
      case (w_eff_state)
         ST_ATTACK: begin
            if ((r_attack == 16'd0) || (w_att_sum >= 17'h0FFFF)) begin
               w_next_level = 16'hFFFF;
               w_next_state = ST_DECAY;
            end else begin
               w_next_level = w_att_sum[15:0];
            end
         end
         ST_DECAY: begin
            if ((r_decay == 16'd0) || ({2'b00, r_level} <= w_dec_floor)) begin
               w_next_level = r_sustain;
               w_next_state = ST_SUSTAIN;
            end else begin
               w_next_level = r_level - w_dec_step[15:0];
            end
         end
         ST_SUSTAIN: begin
            w_next_level = r_sustain;
         end
         ST_RELEASE: begin
            if ((r_release == 16'd0) || ({1'b0, r_level} <= w_rel_step)) begin
               w_next_level = 16'd0;
               w_next_state = ST_IDLE;
            end else begin
               w_next_level = r_level - w_rel_step[15:0];
            end
         end
         default: begin
            w_next_level = 16'd0;
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Register read mux; only driven onto the bus during a selected read.
   always_comb begin
      w_read_data = 32'd0;
      case (w_reg_sel)
         3'd0:    w_read_data = {31'd0, r_gate};
         3'd1:    w_read_data = {16'd0, r_attack};
         3'd2:    w_read_data = {16'd0, r_decay};
         3'd3:    w_read_data = {16'd0, r_sustain};
         3'd4:    w_read_data = {16'd0, r_release};
         3'd5:    w_read_data = {13'd0, r_state, r_level};
         default: w_read_data = 32'd0;
      endcase
      read_value_out = (sel_in && read_in) ? w_read_data : 32'd0;
   end

   // State, level, pending flags and bus registers. A tick consumes flags and
   // uses register values from before any write landing in the same cycle.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         r_tick_q   <= 1'b0;
         r_gate     <= 1'b0;
         r_pend_on  <= 1'b0;
         r_pend_off <= 1'b0;
         r_attack   <= ATTACK_RST;
         r_decay    <= DECAY_RST;
         r_sustain  <= SUSTAIN_RST;
         r_release  <= RELEASE_RST;
         r_level    <= 16'd0;
         r_state    <= ST_IDLE;
      end else begin
         r_tick_q <= sample_tick_in;
         if (w_tick) begin
            r_state <= w_next_state;
            r_level <= w_next_level;
         end
         r_pend_on  <= (r_pend_on  & ~(w_tick & w_clr_on))  | w_set_on;
         r_pend_off <= (r_pend_off & ~(w_tick & w_clr_off)) | w_set_off;
         if (w_wr_en) begin
            case (w_reg_sel)
               3'd0:    r_gate    <= write_value_in[0];
               3'd1:    r_attack  <= write_value_in[15:0];
               3'd2:    r_decay   <= write_value_in[15:0];
               3'd3:    r_sustain <= write_value_in[15:0];
               3'd4:    r_release <= write_value_in[15:0];
               default: ;
            endcase
         end
      end
   end

endmodule
